// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer width, depth and Gray/binary conversion.
// Used by both the write-side and read-side control stages.
package fifo_pkg;

  localparam int unsigned ADDRSIZE_DFLT = 4;
  localparam int unsigned PTR_W_DFLT    = ADDRSIZE_DFLT + 1;

  function automatic int unsigned ptr_width(input int unsigned addrsize);
    return addrsize + 1;
  endfunction

  function automatic int unsigned depth(input int unsigned addrsize);
    return 32'(1) << addrsize;
  endfunction

  // Operates on zero-extended values; callers truncate to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_sync_r2w.sv
// Two-flop synchroniser bringing the read-domain Gray pointer into wclk.
// Mirrored on the read side as sync_w2r.
module sync_r2w #(
  parameter int unsigned W = 5
) (
  input  logic         wclk,
  input  logic         wrst_n,
  input  logic [W-1:0] rptr,
  output logic [W-1:0] wq2_rptr
);

  logic [W-1:0] wq1_rptr_q;
  logic [W-1:0] wq2_rptr_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wq1_rptr_q <= '0;
      wq2_rptr_q <= '0;
    end else begin
      wq1_rptr_q <= rptr;
      wq2_rptr_q <= wq1_rptr_q;
    end
  end

  assign wq2_rptr = wq2_rptr_q;

endmodule

// File: rtl/fifo_wptr_full.sv
// Async FIFO write-side control: write pointer, full/overflow flags, memory write port.
// FIFO_ALMOST_FULL_EN builds the write-side occupancy count and almost-full flag.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE     = 4,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr,
  input  logic                woverflow_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic                wclken,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                woverflow,
  output logic [ADDRSIZE:0]   wcount,
  output logic                walmost_full
);

  localparam int unsigned PTR_W = ptr_width(ADDRSIZE);

  logic [PTR_W-1:0] wq2_rptr;
  logic [PTR_W-1:0] wbin_q, wbin_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic             wfull_q, wfull_d;
  logic             woverflow_q, woverflow_d;
  logic             push;

  sync_r2w #(.W(PTR_W)) u_sync_r2w (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .rptr     (rptr),
    .wq2_rptr (wq2_rptr)
  );

  // Full when the next write pointer sits one lap ahead of the synchronised read pointer.
  always_comb begin
    push        = winc & ~wfull_q;
    wbin_d      = wbin_q + PTR_W'(push);
    wptr_d      = PTR_W'(bin2gray(32'(wbin_d)));
    wfull_d     = (wptr_d == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
    woverflow_d = woverflow_clr ? 1'b0 : (woverflow_q | (winc & wfull_q));
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q      <= '0;
      wptr_q      <= '0;
      wfull_q     <= 1'b0;
      woverflow_q <= 1'b0;
    end else begin
      wbin_q      <= wbin_d;
      wptr_q      <= wptr_d;
      wfull_q     <= wfull_d;
      woverflow_q <= woverflow_d;
    end
  end

  assign waddr     = wbin_q[ADDRSIZE-1:0];
  assign wclken    = push;
  assign wptr      = wptr_q;
  assign wfull     = wfull_q;
  assign woverflow = woverflow_q;

`ifdef FIFO_ALMOST_FULL_EN
  logic [PTR_W-1:0] wcount_q, wcount_d;
  logic             walmost_full_q, walmost_full_d;

  // Modular difference stays in 0..DEPTH because the synced read pointer never leads.
  always_comb begin
    wcount_d       = wbin_d - PTR_W'(gray2bin(32'(wq2_rptr)));
    walmost_full_d = (32'(wcount_d) >= AFULL_THRESH);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wcount_q       <= '0;
      walmost_full_q <= 1'b0;
    end else begin
      wcount_q       <= wcount_d;
      walmost_full_q <= walmost_full_d;
    end
  end

  assign wcount       = wcount_q;
  assign walmost_full = walmost_full_q;
`else
  assign wcount       = '0;
  assign walmost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Randomised self-checking bench for fifo_wptr_full against an occupancy-level model.
module tb_fifo_wptr_full;

  localparam int unsigned A     = 4;
  localparam int unsigned PW    = A + 1;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 12;

  logic          wclk = 1'b0;
  logic          wrst_n;
  logic          winc;
  logic [PW-1:0] rptr;
  logic          woverflow_clr;
  logic [A-1:0]  waddr;
  logic          wclken;
  logic [PW-1:0] wptr;
  logic          wfull;
  logic          woverflow;
  logic [PW-1:0] wcount;
  logic          walmost_full;

  fifo_wptr_full #(.ADDRSIZE(A), .AFULL_THRESH(AF)) dut (
    .wclk          (wclk),
    .wrst_n        (wrst_n),
    .winc          (winc),
    .rptr          (rptr),
    .woverflow_clr (woverflow_clr),
    .waddr         (waddr),
    .wclken        (wclken),
    .wptr          (wptr),
    .wfull         (wfull),
    .woverflow     (woverflow),
    .wcount        (wcount),
    .walmost_full  (walmost_full)
  );

  always #5 wclk = ~wclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: total accepted writes, total reads issued, read count as seen 1 and 2 edges later.
  int wr, rd, rs1, rs2, cnt_m;
  bit full_m, ovf_m, chk_en;

  function automatic logic [PW-1:0] g(input int b);
    logic [PW-1:0] x;
    x = PW'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_count();
`ifdef FIFO_ALMOST_FULL_EN
    return cnt_m;
`else
    return 0;
`endif
  endfunction

  function automatic bit exp_almost();
`ifdef FIFO_ALMOST_FULL_EN
    return cnt_m >= int'(AF);
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge wclk) begin
    if (chk_en && wrst_n) begin
      chk("wptr",      32'(wptr),         32'(g(wr)));
      chk("waddr",     32'(waddr),        32'(wr % DEPTH));
      chk("wfull",     32'(wfull),        32'(full_m));
      chk("woverflow", 32'(woverflow),    32'(ovf_m));
      chk("wclken",    32'(wclken),       32'(winc && !full_m));
      chk("wcount",    32'(wcount),       32'(exp_count()));
      chk("walmost",   32'(walmost_full), 32'(exp_almost()));
    end
  end

  task automatic do_reset(input bit wi);
    wrst_n = 1'b0;
    chk_en = 1'b0;
    winc = wi;
    woverflow_clr = 1'b0;
    wr = 0; rd = 0; rs1 = 0; rs2 = 0; cnt_m = 0;
    full_m = 1'b0; ovf_m = 1'b0;
    rptr = '0;
    #7;
    chk("rst_wptr",   32'(wptr),      32'd0);
    chk("rst_waddr",  32'(waddr),     32'd0);
    chk("rst_wfull",  32'(wfull),     32'd0);
    chk("rst_wovf",   32'(woverflow), 32'd0);
    chk("rst_wcount", 32'(wcount),    32'd0);
    chk("rst_wclken", 32'(wclken),    32'(wi));
    wrst_n = 1'b1;
    #1;
    chk("rel_wptr",  32'(wptr),  32'd0);
    chk("rel_wfull", 32'(wfull), 32'd0);
    chk_en = 1'b1;
  endtask

  task automatic cycle(input bit wi, input bit cl, input bit rd_adv);
    bit push;
    winc = wi;
    woverflow_clr = cl;
    if (rd_adv && rd < wr) rd++;
    rptr = g(rd);
    @(posedge wclk);
    push  = wi && !full_m;
    ovf_m = cl ? 1'b0 : (ovf_m | (wi && full_m));
    wr    = wr + int'(push);
    cnt_m = wr - rs2;
    full_m = (cnt_m == int'(DEPTH));
    rs2 = rs1;
    rs1 = rd;
    #1;
  endtask

  initial begin
    wrst_n = 1'b0; winc = 1'b1; woverflow_clr = 1'b0; rptr = '0;
    do_reset(1'b1);

    // Fill to full with the read side idle.
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("fill_wptr",  32'(wptr),  32'b11000);
    chk("fill_wfull", 32'(wfull), 32'd1);

    // Writes while full are dropped and flagged; clear beats a coincident event.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
    chk("ovf_set",    32'(woverflow), 32'd1);
    chk("ovf_waddr",  32'(waddr),     32'd0);
    chk("ovf_wclken", 32'(wclken),    32'd0);
    cycle(1'b1, 1'b1, 1'b0);
    chk("ovf_clr", 32'(woverflow), 32'd0);

    // One read: full drops only after the third edge.
    cycle(1'b0, 1'b0, 1'b1);
    chk("rel_e1", 32'(wfull), 32'd1);
    cycle(1'b0, 1'b0, 1'b0);
    chk("rel_e2", 32'(wfull), 32'd1);
    cycle(1'b0, 1'b0, 1'b0);
    chk("rel_e3", 32'(wfull), 32'd0);

    // Almost-full threshold boundary.
    do_reset(1'b0);
    for (int i = 0; i < 11; i++) cycle(1'b1, 1'b0, 1'b0);
`ifdef FIFO_ALMOST_FULL_EN
    chk("af11_cnt", 32'(wcount), 32'd11);
`else
    chk("af11_cnt", 32'(wcount), 32'd0);
`endif
    chk("af11_flag", 32'(walmost_full), 32'd0);
    cycle(1'b1, 1'b0, 1'b0);
`ifdef FIFO_ALMOST_FULL_EN
    chk("af12_cnt",  32'(wcount),       32'd12);
    chk("af12_flag", 32'(walmost_full), 32'd1);
`else
    chk("af12_cnt",  32'(wcount),       32'd0);
    chk("af12_flag", 32'(walmost_full), 32'd0);
`endif

    // Wrap: reader keeps up, 40 writes pass the pointer MSB twice.
    do_reset(1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'b1);
    chk("wrap_wptr",  32'(wptr),  32'b01100);
    chk("wrap_wfull", 32'(wfull), 32'd0);

    // Random traffic with a reset dropped in mid-run.
    do_reset(1'b0);
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset(1'($urandom_range(1)));
      cycle($urandom_range(99) < 65, $urandom_range(99) < 8, $urandom_range(99) < 45);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
